// File: rtl/multi_slow_clk_if.sv
// Control/status bundle for multi_slow_clk: enables, per-channel half-periods
// in, slow clocks and edge pulses out.
interface multi_slow_clk_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
);
  logic                 EN;
  logic                 FAST;
  logic                 SYNC_CLR;
  logic [NCH*CNT_W-1:0] PERIOD;
  logic [NCH-1:0]       SLWCLK;
  logic [NCH-1:0]       TICK;
  logic [NCH-1:0]       HALF;

  modport master (output EN, FAST, SYNC_CLR, PERIOD, input SLWCLK, TICK, HALF);
  modport slave  (input EN, FAST, SYNC_CLR, PERIOD, output SLWCLK, TICK, HALF);
endinterface

// File: rtl/multi_slow_clk.sv
// NCH independent slow clocks derived from CLK100MHZ by remainder-carrying
// accumulators, with registered TICK (rising) and HALF (any toggle) pulses.
module msc_lane #(
  parameter int          CNT_W     = 32,
  parameter int unsigned FAST_STEP = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fast,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             slwclk,
  output logic             tick,
  output logic             half
);
  localparam logic [CNT_W-1:0] STEP_F = CNT_W'(FAST_STEP);

  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] step;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   rem;
  logic             wrap;

  // one extra bit keeps acc + step exact even at the top of the range
  always_comb begin
    step = fast ? STEP_F : CNT_W'(1);
    sum  = {1'b0, acc} + {1'b0, step};
    rem  = sum - {1'b0, period};
    wrap = (sum >= {1'b0, period});
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc    <= '0;
      slwclk <= 1'b0;
      tick   <= 1'b0;
      half   <= 1'b0;
    end else begin
      tick <= 1'b0;
      half <= 1'b0;
      if (period == '0) begin
        acc    <= '0;
        slwclk <= 1'b0;
      end else if (en) begin
        if (!wrap) begin
          acc <= sum[CNT_W-1:0];
        end else begin
          // clamp: a remainder that still spans a period is dropped, so a
          // shrunken PERIOD cannot leave a runaway backlog
          acc    <= (rem >= {1'b0, period}) ? '0 : rem[CNT_W-1:0];
          slwclk <= ~slwclk;
          half   <= 1'b1;
          tick   <= ~slwclk;
        end
      end
    end
  end
endmodule

module multi_slow_clk #(
  parameter int          CNT_W     = 32,
  parameter int          NCH       = 2,
  parameter int unsigned FAST_STEP = 120
) (
  input  logic            CLK100MHZ,
  input  logic            RESET,
  multi_slow_clk_if.slave bus
);
  logic [NCH-1:0] slw_v;
  logic [NCH-1:0] tick_v;
  logic [NCH-1:0] half_v;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    msc_lane #(.CNT_W(CNT_W), .FAST_STEP(FAST_STEP)) u_lane (
      .clk    (CLK100MHZ),
      .rst    (RESET),
      .en     (bus.EN),
      .fast   (bus.FAST),
      .clr    (bus.SYNC_CLR),
      .period (bus.PERIOD[i*CNT_W +: CNT_W]),
      .slwclk (slw_v[i]),
      .tick   (tick_v[i]),
      .half   (half_v[i])
    );
  end

  assign bus.SLWCLK = slw_v;
  assign bus.TICK   = tick_v;
  assign bus.HALF   = half_v;
endmodule

// File: tb/tb_multi_slow_clk.sv
// Directed bench: a vector table for reset/normal/enable/clear/fast-mode
// behaviour plus hand sequences for period changes and the 32-bit extreme.
module tb_multi_slow_clk;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multi_slow_clk_if #(.NCH(2), .CNT_W(32)) bus ();
  multi_slow_clk_if #(.NCH(1), .CNT_W(32)) bx ();

  multi_slow_clk #(.CNT_W(32), .NCH(2), .FAST_STEP(120)) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  multi_slow_clk #(.CNT_W(32), .NCH(1), .FAST_STEP(32'hFFFF_FFF0)) dut_x (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .bus       (bx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, fast, clr;
    logic [31:0] p1, p0;
    logic [1:0]  slw, tick, half;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic e, input logic f,
                     input logic c, input logic [31:0] p1, input logic [31:0] p0,
                     input logic [1:0] s, input logic [1:0] t, input logic [1:0] h);
    vec_t v;
    v.rst = r; v.en = e; v.fast = f; v.clr = c; v.p1 = p1; v.p0 = p0;
    v.slw = s; v.tick = t; v.half = h;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic c,
                       input logic [31:0] p1, input logic [31:0] p0);
    bus.EN = e; bus.FAST = f; bus.SYNC_CLR = c; bus.PERIOD = {p1, p0};
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [1:0] s,
                         input logic [1:0] t, input logic [1:0] h);
    chk({name, " slw"},  {62'd0, bus.SLWCLK}, {62'd0, s});
    chk({name, " tick"}, {62'd0, bus.TICK},   {62'd0, t});
    chk({name, " half"}, {62'd0, bus.HALF},   {62'd0, h});
  endtask

  initial begin
    int ticks, halves, bad, other;
    logic [1:0] es, et, eh;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd8, 32'd4);
    bx.EN = 1'b0; bx.FAST = 1'b0; bx.SYNC_CLR = 1'b0; bx.PERIOD = '0;

    //   n  rst en fs clr p1  p0   slw    tick   half
    add(3,  1, 1, 0, 0, 8, 4,   2'b00, 2'b00, 2'b00);
    add(3,  0, 1, 0, 0, 8, 4,   2'b00, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b01, 2'b01, 2'b01);
    add(3,  0, 1, 0, 0, 8, 4,   2'b01, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b10, 2'b10, 2'b11);
    add(3,  0, 1, 0, 0, 8, 4,   2'b10, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b11, 2'b01, 2'b01);
    add(3,  0, 1, 0, 0, 8, 4,   2'b11, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b00, 2'b00, 2'b11);
    add(2,  0, 1, 0, 0, 8, 4,   2'b00, 2'b00, 2'b00);
    add(5,  0, 0, 0, 0, 8, 4,   2'b00, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b00, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b01, 2'b01, 2'b01);
    add(1,  0, 1, 0, 1, 8, 4,   2'b00, 2'b00, 2'b00);
    add(3,  0, 1, 0, 0, 8, 4,   2'b00, 2'b00, 2'b00);
    add(1,  0, 1, 0, 0, 8, 4,   2'b01, 2'b01, 2'b01);
    add(1,  0, 1, 1, 1, 0, 300, 2'b00, 2'b00, 2'b00);
    add(2,  0, 1, 1, 0, 0, 300, 2'b00, 2'b00, 2'b00);
    add(1,  0, 1, 1, 0, 0, 300, 2'b01, 2'b01, 2'b01);
    add(1,  0, 1, 1, 0, 0, 300, 2'b01, 2'b00, 2'b00);
    add(1,  0, 1, 1, 0, 0, 300, 2'b00, 2'b00, 2'b01);
    add(2,  0, 1, 1, 0, 0, 300, 2'b00, 2'b00, 2'b00);
    add(1,  0, 1, 1, 0, 0, 300, 2'b01, 2'b01, 2'b01);
    add(1,  0, 1, 1, 0, 0, 300, 2'b01, 2'b00, 2'b00);
    add(1,  0, 1, 1, 0, 0, 300, 2'b00, 2'b00, 2'b01);

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].en, tbl[i].fast, tbl[i].clr, tbl[i].p1, tbl[i].p0);
      step_clk();
      chk_out($sformatf("vec%0d", i), tbl[i].slw, tbl[i].tick, tbl[i].half);
    end
    rst = 1'b0;

    // 40 normal cycles at PERIOD=4: 10 toggles, 5 of them rising
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd4);
    step_clk();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd4);
    ticks = 0; halves = 0; bad = 0; other = 0;
    for (int k = 0; k < 40; k++) begin
      step_clk();
      ticks  += int'(bus.TICK[0]);
      halves += int'(bus.HALF[0]);
      if (bus.TICK[0] && !bus.SLWCLK[0]) bad++;
      if (bus.SLWCLK[1] || bus.TICK[1] || bus.HALF[1]) other++;
    end
    chk("p4 ticks",   ticks, 5);
    chk("p4 halves",  halves, 10);
    chk("p4 tick_on_fall", bad, 0);
    chk("p4 ch1_idle", other, 0);

    // shrink PERIOD 100->3 with acc=50: immediate toggle, then acc restarts at 0
    drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd100);
    step_clk();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd100);
    for (int k = 0; k < 50; k++) step_clk();
    chk_out("p100 acc50", 2'b00, 2'b00, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd3);
    step_clk();
    chk_out("shrink toggle", 2'b01, 2'b01, 2'b01);
    step_clk();
    step_clk();
    chk_out("shrink hold", 2'b01, 2'b00, 2'b00);
    step_clk();
    chk_out("shrink p3", 2'b00, 2'b00, 2'b01);

    // ch0 PERIOD=1 toggles every edge; ch1 PERIOD=2, then disabled while high
    drive(1'b1, 1'b0, 1'b1, 32'd2, 32'd1);
    step_clk();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, (k <= 6) ? 32'd2 : 32'd0, 32'd1);
      step_clk();
      es = {(k <= 6) && (k % 4 >= 2), k[0]};
      et = {(k <= 6) && (k % 4 == 2), k[0]};
      eh = {(k <= 6) && (k % 2 == 0), 1'b1};
      chk_out($sformatf("p1p2 k%0d", k), es, et, eh);
    end

    // 32-bit extreme: step + acc exceeds 2^32, must not wrap
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bx.EN = 1'b1; bx.FAST = 1'b1; bx.PERIOD = 32'hFFFF_FFFF; bx.SYNC_CLR = 1'b1;
    step_clk();
    bx.SYNC_CLR = 1'b0;
    step_clk();
    chk("wide e1 slw", {63'd0, bx.SLWCLK}, 64'd0);
    step_clk();
    chk("wide e2 slw",  {63'd0, bx.SLWCLK}, 64'd1);
    chk("wide e2 tick", {63'd0, bx.TICK},   64'd1);
    step_clk();
    chk("wide e3 slw",  {63'd0, bx.SLWCLK}, 64'd0);
    chk("wide e3 half", {63'd0, bx.HALF},   64'd1);
    step_clk();
    chk("wide e4 slw",  {63'd0, bx.SLWCLK}, 64'd1);
    chk("wide e4 tick", {63'd0, bx.TICK},   64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
